// File: rtl/dlsc_uart_tx_core.sv
// dlsc_uart_tx_core: parameterised UART transmitter.
// Frames one character per handshake as start / data (LSB first) / optional
// parity / stop bits. Each bit lasts OVERSAMPLE clk_en ticks. tx and
// tx_active are registered so they can drive a line or an RS-485 enable directly.
module dlsc_uart_tx_core #(
    parameter int START      = 1,   // start bits (1-2), driven low
    parameter int STOP       = 1,   // stop bits (1-2), driven high
    parameter int DATA       = 8,   // data bits per frame (5-9)
    parameter int PARITY     = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int OVERSAMPLE = 16   // clk_en ticks per bit period (>= 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    output logic            ready,
    input  logic            valid,
    input  logic [DATA-1:0] data,
    output logic            tx,
    output logic            tx_active
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] START_LAST = BW'(START - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t          state_q,     state_d;
    logic [TW-1:0]   tick_q,      tick_d;
    logic [BW-1:0]   bit_q,       bit_d;
    logic [DATA-1:0] shift_q,     shift_d;
    logic            par_q,       par_d;
    logic            tx_q,        tx_d;
    logic            tx_active_q, tx_active_d;
    logic            ready_q,     ready_d;

    logic            bit_end;

    // A bit period closes on the OVERSAMPLE-th clk_en tick since it began.
    assign bit_end = clk_en && (tick_q == TICK_LAST);

    // Next-state logic: sequences the frame and precomputes every registered output.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        ready_d     = ready_q;

        // Sub-bit counter only moves on clk_en, so a stalled tick source freezes the line.
        if (state_q != S_IDLE && clk_en) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                ready_d     = 1'b1;
                tx_d        = 1'b1;
                tx_active_d = 1'b0;
                tick_d      = '0;
                bit_d       = '0;
                if (ready_q && valid) begin
                    state_d     = S_START;
                    shift_d     = data;
                    par_d       = (PARITY == 1) ? ~^data : ^data;
                    tx_d        = 1'b0;
                    tx_active_d = 1'b1;
                    ready_d     = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    if (bit_q == START_LAST) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end

            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        ready_d = 1'b1;
                        // A waiting character keeps the driver enabled across the
                        // single handover cycle so back-to-back frames stay contiguous.
                        tx_active_d = valid;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            ready_q     <= ready_d;
        end
    end

    assign tx        = tx_q;
    assign tx_active = tx_active_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_dlsc_uart_tx_core.sv
// tb_dlsc_uart_tx_core: directed bench for dlsc_uart_tx_core.
// Five instances cover 8N1/16x, even parity, odd parity, 8N1/4x with a
// divided tick, and 2-start/7-data/2-stop. Expected waveforms are hand-built
// bit vectors (index 0 = first bit on the wire) walked with a tick-count model.
module tb_dlsc_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en_r [5];
    logic       valid_r  [5];
    logic [8:0] data_r   [5];
    logic       tx_w     [5];
    logic       txa_w    [5];
    logic       rdy_w    [5];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dlsc_uart_tx_core #(.START(1), .STOP(1), .DATA(8), .PARITY(0), .OVERSAMPLE(16)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en_r[0]), .ready(rdy_w[0]),
        .valid(valid_r[0]), .data(data_r[0][7:0]), .tx(tx_w[0]), .tx_active(txa_w[0]));

    dlsc_uart_tx_core #(.START(1), .STOP(1), .DATA(8), .PARITY(2), .OVERSAMPLE(16)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en_r[1]), .ready(rdy_w[1]),
        .valid(valid_r[1]), .data(data_r[1][7:0]), .tx(tx_w[1]), .tx_active(txa_w[1]));

    dlsc_uart_tx_core #(.START(1), .STOP(1), .DATA(8), .PARITY(1), .OVERSAMPLE(16)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en_r[2]), .ready(rdy_w[2]),
        .valid(valid_r[2]), .data(data_r[2][7:0]), .tx(tx_w[2]), .tx_active(txa_w[2]));

    dlsc_uart_tx_core #(.START(1), .STOP(1), .DATA(8), .PARITY(0), .OVERSAMPLE(4)) u_os4 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en_r[3]), .ready(rdy_w[3]),
        .valid(valid_r[3]), .data(data_r[3][7:0]), .tx(tx_w[3]), .tx_active(txa_w[3]));

    dlsc_uart_tx_core #(.START(2), .STOP(2), .DATA(7), .PARITY(0), .OVERSAMPLE(8)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en_r[4]), .ready(rdy_w[4]),
        .valid(valid_r[4]), .data(data_r[4][6:0]), .tx(tx_w[4]), .tx_active(txa_w[4]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one character on instance sel and checks every cycle of the frame.
    // Instance 3 gets clk_en on every 4th edge; edges in [fz_start, fz_start+fz_len)
    // have clk_en forced low. A mid-bit sampling receiver rebuilds the frame too.
    task automatic check_frame(input int sel, input logic [8:0] d, input logic [15:0] bits,
                               input int nbits, input int os, input int exp_len,
                               input int fz_start, input int fz_len, input string name);
        int          e;
        int          p;
        int          errs;
        int          bad_e;
        logic        bad_tx, bad_txa, bad_rdy, bad_exp;
        logic        en;
        logic [15:0] rx;
        int          total;

        total = nbits * os;
        tests++;
        if (rdy_w[sel] !== 1'b1) begin
            fails++;
            $display("FAIL %s ready-before-send: ready=%b, required 1", name, rdy_w[sel]);
        end

        valid_r[sel]  = 1'b1;
        data_r[sel]   = d;
        clk_en_r[sel] = 1'b1;
        tick();
        valid_r[sel] = 1'b0;
        data_r[sel]  = ~d;

        e = 0; p = 0; errs = 0; rx = '0;
        bad_e = 0; bad_tx = 0; bad_txa = 0; bad_rdy = 0; bad_exp = 0;
        while (p < total && e < 4000) begin
            if (tx_w[sel] !== bits[p / os] || txa_w[sel] !== 1'b1 || rdy_w[sel] !== 1'b0) begin
                if (errs == 0) begin
                    bad_e = e; bad_tx = tx_w[sel]; bad_txa = txa_w[sel];
                    bad_rdy = rdy_w[sel]; bad_exp = bits[p / os];
                end
                errs++;
            end
            en = (sel == 3) ? (((e + 1) % 4) == 0) : 1'b1;
            if (e + 1 >= fz_start && e + 1 < fz_start + fz_len) en = 1'b0;
            clk_en_r[sel] = en;
            valid_r[sel]  = (e >= 20 && e < 24);
            tick();
            e++;
            if (en) begin
                p++;
                if ((p % os) == (os / 2) && p < total) rx[p / os] = tx_w[sel];
            end
        end
        valid_r[sel]  = 1'b0;
        clk_en_r[sel] = 1'b1;

        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL %s waveform: %0d bad cycles, first at cycle %0d tx=%b tx_active=%b ready=%b, required tx=%b tx_active=1 ready=0",
                     name, errs, bad_e, bad_tx, bad_txa, bad_rdy, bad_exp);
        end
        tests++;
        if (e != exp_len) begin
            fails++;
            $display("FAIL %s frame-length: %0d cycles, required %0d", name, e, exp_len);
        end
        tests++;
        if (tx_w[sel] !== 1'b1 || txa_w[sel] !== 1'b0 || rdy_w[sel] !== 1'b1) begin
            fails++;
            $display("FAIL %s end-of-frame: tx=%b tx_active=%b ready=%b, required 1 0 1",
                     name, tx_w[sel], txa_w[sel], rdy_w[sel]);
        end
        tests++;
        if (rx !== bits) begin
            fails++;
            $display("FAIL %s receiver: got %h, required %h", name, rx, bits);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_r[i] = 1'b1; clk_en_r[i] = 1'b1; data_r[i] = 9'h155;
        end
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (tx_w[i] !== 1'b1 || txa_w[i] !== 1'b0 || rdy_w[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset-state[%0d]: tx=%b tx_active=%b ready=%b, required 1 0 0",
                         i, tx_w[i], txa_w[i], rdy_w[i]);
            end
        end
        for (int i = 0; i < 5; i++) valid_r[i] = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rdy_w[i] !== 1'b1 || tx_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset-release[%0d]: ready=%b tx=%b, required 1 1", i, rdy_w[i], tx_w[i]);
            end
        end
    endtask

    task automatic test_basic();
        // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1 on the wire
        check_frame(0, 9'h0A5, 16'h034A, 10, 16, 160, 0, 0, "8n1-a5");
    endtask

    task automatic test_parity();
        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        check_frame(1, 9'h007, 16'h060E, 11, 16, 176, 0, 0, "even-07");
        check_frame(2, 9'h007, 16'h040E, 11, 16, 176, 0, 0, "odd-07");
    endtask

    task automatic test_clk_en();
        // 0x5A with clk_en every 4th cycle: 16 clk cycles per bit
        check_frame(3, 9'h05A, 16'h02B4, 10, 4, 160, 0, 0, "os4-5a");
        // clk_en held low for 100 cycles inside bit 2 stretches the frame by 100
        check_frame(3, 9'h05A, 16'h02B4, 10, 4, 260, 38, 100, "os4-freeze");
    endtask

    task automatic test_frame_format();
        // 0x55 as 7 data bits with 2 start / 2 stop: 0,0,1,0,1,0,1,0,1,1,1
        check_frame(4, 9'h055, 16'h0754, 11, 8, 88, 0, 0, "7n2-55");
    endtask

    task automatic test_back_to_back();
        logic [15:0] bv [3];
        int          errs;
        int          low_act;
        int          f;
        int          o;
        logic        exp_tx, exp_txa, exp_rdy;

        bv[0] = 16'h0222;  // 0x11
        bv[1] = 16'h0244;  // 0x22
        bv[2] = 16'h0266;  // 0x33
        errs = 0; low_act = 0;
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h011;
        tick();
        for (int e = 0; e <= 482; e++) begin
            f = e / 161;
            o = e % 161;
            if (o < 160) begin
                exp_tx = bv[f][o / 16]; exp_txa = 1'b1; exp_rdy = 1'b0;
            end else begin
                exp_tx = 1'b1; exp_txa = (f < 2); exp_rdy = 1'b1;
            end
            if (tx_w[0] !== exp_tx || txa_w[0] !== exp_txa || rdy_w[0] !== exp_rdy) begin
                if (errs == 0)
                    $display("FAIL b2b waveform at cycle %0d: tx=%b tx_active=%b ready=%b, required %b %b %b",
                             e, tx_w[0], txa_w[0], rdy_w[0], exp_tx, exp_txa, exp_rdy);
                errs++;
            end
            if (e < 482 && txa_w[0] !== 1'b1) low_act++;
            if (e == 0)   data_r[0] = 9'h022;
            if (e == 161) data_r[0] = 9'h033;
            if (e == 322) valid_r[0] = 1'b0;
            if (e < 482) tick();
        end
        tests++;
        if (errs != 0) fails++;
        tests++;
        if (low_act != 0) begin
            fails++;
            $display("FAIL b2b tx_active-gap: %0d low cycles, required 0", low_act);
        end
    endtask

    task automatic test_reset_mid_frame();
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h000;
        tick();
        valid_r[0] = 1'b0;
        repeat (70) tick();  // inside data bit 3 (cycles 64..79)
        tests++;
        if (tx_w[0] !== 1'b0 || txa_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL midreset pre: tx=%b tx_active=%b, required 0 1", tx_w[0], txa_w[0]);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) valid_r[i] = 1'b1;
        tick();
        tests++;
        if (tx_w[0] !== 1'b1 || txa_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset abort: tx=%b tx_active=%b ready=%b, required 1 0 0",
                     tx_w[0], txa_w[0], rdy_w[0]);
        end
        repeat (3) tick();
        tests++;
        if (rdy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL midreset hold: ready=%b tx=%b, required 0 1", rdy_w[0], tx_w[0]);
        end
        for (int i = 0; i < 5; i++) valid_r[i] = 1'b0;
        rst_n = 1'b1;
        tick();
        tests++;
        if (rdy_w[0] !== 1'b1 || tx_w[0] !== 1'b1 || txa_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset release: ready=%b tx=%b tx_active=%b, required 1 1 0",
                     rdy_w[0], tx_w[0], txa_w[0]);
        end
        check_frame(0, 9'h03C, 16'h0278, 10, 16, 160, 0, 0, "after-reset-3c");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_en_r[i] = 1'b1; valid_r[i] = 1'b0; data_r[i] = '0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_clk_en();
        test_frame_format();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dlsc_uart_tx_core.md
DLSC_UART_TX_CORE -- requirements
Module: dlsc_uart_tx_core

Interface
REQ-001 Parameter START, default 1: number of start bits (1-2), driven low.
REQ-002 Parameter STOP, default 1: number of stop bits (1-2), driven high.
REQ-003 Parameter DATA, default 8: data bits per frame (5-9).
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter OVERSAMPLE, default 16: clk_en pulses per bit period (>= 2).
REQ-006 Clock and reset: one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 clk_en  input  1  oversample tick from an external clock synthesizer.
REQ-010 ready  output  1  core can accept a character this cycle.
REQ-011 valid  input  1  character present on data.
REQ-012 data  input  DATA  character to transmit, LSB first.
REQ-013 tx  output  1  serial UART line, idle high, registered.
REQ-014 tx_active  output  1  high for the whole frame (RS-485 driver enable), registered.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PAR, STOP, traversed in that order; PAR SHALL be skipped when PARITY = 0.
REQ-016 ready SHALL be high only in IDLE; a character is accepted on the cycle where valid && ready.
REQ-017 On acceptance: data latched into the shift register; parity computed from latched data; FSM goes to START; ready low the next cycle.
REQ-018 valid without ready SHALL be ignored; data changes while not ready SHALL NOT affect the frame in progress.
REQ-019 tx and tx_active SHALL go low and high respectively on the cycle after acceptance.
REQ-020 The bit counter SHALL count clk_en pulses; each bit SHALL end on the OVERSAMPLE-th clk_en pulse counted from its start (the first bit therefore includes the partial tick after acceptance).
REQ-021 The sub-bit counter SHALL advance only when clk_en = 1; with clk_en held low, tx SHALL hold its value indefinitely.
REQ-022 START SHALL last START bit periods; DATA SHALL shift out DATA bits LSB first; PAR SHALL send one bit.
REQ-023 Odd parity bit = ~^data; even parity bit = ^data (ones count over the DATA bits only).
REQ-024 STOP SHALL drive tx high for STOP bit periods.
REQ-025 On the final clk_en of the last stop bit, the FSM SHALL return to IDLE; tx_active low and ready high the next cycle.
REQ-026 Back-to-back: if valid is high when ready rises, the next start bit begins the following cycle with no extra idle bit.
REQ-027 Frame length SHALL be exactly (START + DATA + (PARITY != 0) + STOP) * OVERSAMPLE clk_en pulses, plus the partial first tick.
REQ-028 Counter widths SHALL be ceil(log2(OVERSAMPLE)) bits and ceil(log2(DATA + 1)) bits; no wrap SHALL occur within a state.

Reset
REQ-029 While rst_n = 0: tx = 1, tx_active = 0, ready = 0, FSM in IDLE, counters at 0.
REQ-030 ready SHALL assert on the first cycle after rst_n returns high.
REQ-031 Reset mid-frame SHALL abort the frame; tx SHALL go high on the next edge with no partial bits afterwards.
REQ-032 valid during reset SHALL be ignored.

Verification
REQ-033 Default parameters, clk_en = 1 every cycle, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; ready high again 160 cycles after acceptance.
REQ-034 PARITY = 2, send 0x07 (three ones) -> parity bit = 1; PARITY = 1, send 0x07 -> parity bit = 0; frame length 176 cycles.
REQ-035 clk_en every 4th cycle, OVERSAMPLE = 4 -> each bit lasts 16 clk cycles; with clk_en forced low for 100 cycles mid-bit, tx is frozen and the bit length is extended by exactly 100 cycles.
REQ-036 valid held high with a stream of 3 bytes -> 3 contiguous frames, no idle gap, tx_active continuously high.
REQ-037 rst_n pulled low during data bit 3 -> tx = 1 and tx_active = 0 the next cycle; after release, ready = 1 and a new 0x3C frame is sent correctly.
REQ-038 START = 2, STOP = 2, DATA = 7 -> start low for 2 bit periods, 7 data bits, stop high for 2 bit periods; checked against a reference UART receiver model.
